// File: rtl/branch_checkpoint_ctrl_if.sv
// Rename/commit/recovery signal bundle for the branch checkpoint controller.
// The master drives branch events; the slave returns the restore path.
interface branch_checkpoint_ctrl_if #(
    parameter int REG   = 4,
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int CKPT  = 4
);
    logic                      branchAlloc;
    logic [ROB:0]              branchROB;
    logic [WIDTH:0]            regStatusSnap;
    logic                      freeValid;
    logic [REG:0]              freeReg;
    logic                      branchCommit;
    logic                      mispredict;
    logic [ROB:0]              mispredictROB;
    logic [WIDTH:0]            statusRestore;
    logic                      restoreReq;
    logic                      stall;
    logic [$clog2(CKPT):0]     ckptCount;
    logic                      missErr;

    modport master (
        output branchAlloc, branchROB, regStatusSnap, freeValid, freeReg,
               branchCommit, mispredict, mispredictROB,
        input  statusRestore, restoreReq, stall, ckptCount, missErr
    );

    modport slave (
        input  branchAlloc, branchROB, regStatusSnap, freeValid, freeReg,
               branchCommit, mispredict, mispredictROB,
        output statusRestore, restoreReq, stall, ckptCount, missErr
    );
endinterface

// File: rtl/branch_checkpoint_ctrl.sv
// Circular FIFO of register-busy snapshots taken at each branch; a mispredict
// restores the oldest matching snapshot and squashes it plus all younger slots.
module branch_checkpoint_ctrl #(
    parameter int REG   = 4,
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int CKPT  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_checkpoint_ctrl_if.slave bus
);
    localparam int PW = (CKPT > 1) ? $clog2(CKPT) : 1;
    localparam int CW = $clog2(CKPT) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        RECOVER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q [CKPT];
    logic            valid_d [CKPT];
    logic [ROB:0]    tag_q   [CKPT];
    logic [ROB:0]    tag_d   [CKPT];
    logic [WIDTH:0]  snap_q  [CKPT];
    logic [WIDTH:0]  snap_d  [CKPT];
    logic [WIDTH:0]  status_q, status_d;
    logic            restore_q, restore_d;
    logic            miss_q, miss_d;

    logic [WIDTH:0]  free_mask_s;
    logic            stall_s;
    logic            hit_s;
    logic [PW-1:0]   hit_idx_s;
    logic [CW-1:0]   hit_dist_s;
    logic [PW-1:0]   scan_idx_s;
    logic [PW-1:0]   off_s;
    logic            do_commit_s;
    logic            do_alloc_s;

    assign stall_s = (count_q == CW'(CKPT)) || (state_q != IDLE);

    // Next-state for slots, pointers, FSM and the restore path.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        snap_d     = snap_q;
        status_d   = status_q;
        restore_d  = 1'b0;
        miss_d     = miss_q;
        free_mask_s = '0;
        hit_s       = 1'b0;
        hit_idx_s   = '0;
        hit_dist_s  = '0;
        scan_idx_s  = '0;
        off_s       = '0;

        if (bus.freeValid && (bus.freeReg != '0)) begin
            free_mask_s[bus.freeReg] = 1'b1;
        end else begin
            free_mask_s = '0;
        end
        for (int j = 0; j < CKPT; j++) begin
            snap_d[j] = snap_q[j] & ~free_mask_s;
        end

        // Scan from head so the first match found is the oldest.
        for (int k = 0; k < CKPT; k++) begin
            scan_idx_s = head_q + PW'(k);
            if (!hit_s && valid_q[scan_idx_s] && (tag_q[scan_idx_s] == bus.mispredictROB)) begin
                hit_s      = 1'b1;
                hit_idx_s  = scan_idx_s;
                hit_dist_s = CW'(k);
            end else begin
                hit_s = hit_s;
            end
        end

        do_commit_s = bus.branchCommit && (count_q != '0);
        do_alloc_s  = bus.branchAlloc && !stall_s;

        case (state_q)
            IDLE: begin
                if (bus.mispredict && hit_s) begin
                    for (int j = 0; j < CKPT; j++) begin
                        off_s = PW'(j) - head_q;
                        if ({1'b0, off_s} >= hit_dist_s) begin
                            valid_d[j] = 1'b0;
                        end else begin
                            valid_d[j] = valid_q[j];
                        end
                    end
                    tail_d  = hit_idx_s;
                    count_d = hit_dist_s;
                    if (do_commit_s && (hit_dist_s != '0)) begin
                        valid_d[head_q] = 1'b0;
                        head_d  = head_q + PW'(1);
                        count_d = hit_dist_s - CW'(1);
                    end else begin
                        head_d = head_q;
                    end
                    status_d  = snap_q[hit_idx_s] & ~free_mask_s;
                    restore_d = 1'b1;
                    state_d   = RESTORE;
                end else begin
                    if (bus.mispredict) begin
                        miss_d = 1'b1;
                    end else begin
                        miss_d = miss_q;
                    end
                    if (do_commit_s) begin
                        valid_d[head_q] = 1'b0;
                        head_d = head_q + PW'(1);
                    end else begin
                        head_d = head_q;
                    end
                    if (do_alloc_s) begin
                        valid_d[tail_q] = 1'b1;
                        tag_d[tail_q]   = bus.branchROB;
                        snap_d[tail_q]  = bus.regStatusSnap & ~free_mask_s;
                        tail_d = tail_q + PW'(1);
                    end else begin
                        tail_d = tail_q;
                    end
                    count_d = count_q + CW'(do_alloc_s) - CW'(do_commit_s);
                    state_d = IDLE;
                end
            end
            RESTORE, RECOVER: begin
                // Allocation is stalled here; commits still drain the head.
                if (do_commit_s) begin
                    valid_d[head_q] = 1'b0;
                    head_d  = head_q + PW'(1);
                    count_d = count_q - CW'(1);
                end else begin
                    head_d = head_q;
                end
                state_d = (state_q == RESTORE) ? RECOVER : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            status_q  <= '0;
            restore_q <= 1'b0;
            miss_q    <= 1'b0;
            for (int j = 0; j < CKPT; j++) begin
                valid_q[j] <= 1'b0;
                tag_q[j]   <= '0;
                snap_q[j]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            status_q  <= status_d;
            restore_q <= restore_d;
            miss_q    <= miss_d;
            for (int j = 0; j < CKPT; j++) begin
                valid_q[j] <= valid_d[j];
                tag_q[j]   <= tag_d[j];
                snap_q[j]  <= snap_d[j];
            end
        end
    end

    assign bus.statusRestore = status_q;
    assign bus.restoreReq    = restore_q;
    assign bus.stall         = stall_s;
    assign bus.ckptCount     = count_q;
    assign bus.missErr       = miss_q;
endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
// Scoreboard bench: a queue-of-checkpoints model predicts every cycle's outputs;
// a monitor pops and compares one expectation per clock.
module tb_branch_checkpoint_ctrl;
    localparam int CKPT = 4;

    logic clk;
    logic reset;

    branch_checkpoint_ctrl_if #(.REG(4), .WIDTH(31), .ROB(2), .CKPT(CKPT)) bus ();

    branch_checkpoint_ctrl #(.REG(4), .WIDTH(31), .ROB(2), .CKPT(CKPT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] status;
        logic        rreq;
        logic        stall;
        logic [2:0]  count;
        logic        miss;
    } exp_t;

    typedef struct {
        logic [2:0]  tag;
        logic [31:0] snap;
    } ent_t;

    exp_t        exq [$];
    ent_t        mq  [$];
    int          m_busy;
    logic [31:0] m_status;
    logic        m_rreq;
    logic        m_miss;
    int          checks;
    int          errors;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endfunction

    // One clock of stimulus: drive inputs, advance the model, queue the expectation.
    task automatic cyc(input logic rst, input logic al, input logic [2:0] at, input logic [31:0] sn,
                       input logic fv, input logic [4:0] fr, input logic cm,
                       input logic mp, input logic [2:0] mt);
        logic [31:0] mask;
        int          hit;
        bit          can_alloc;
        exp_t        e;
        @(negedge clk);
        reset                 = rst;
        bus.branchAlloc       = al;
        bus.branchROB         = at;
        bus.regStatusSnap     = sn;
        bus.freeValid         = fv;
        bus.freeReg           = fr;
        bus.branchCommit      = cm;
        bus.mispredict        = mp;
        bus.mispredictROB     = mt;
        if (rst) begin
            mq.delete();
            m_busy = 0;
            m_status = 32'd0;
            m_rreq = 1'b0;
            m_miss = 1'b0;
        end else begin
            mask = (fv && fr != 5'd0) ? (32'd1 << fr) : 32'd0;
            foreach (mq[k]) mq[k].snap = mq[k].snap & ~mask;
            hit = -1;
            if (mp && m_busy == 0) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (hit < 0 && mq[k].tag == mt) hit = k;
                end
            end
            m_rreq = 1'b0;
            if (hit >= 0) begin
                m_status = mq[hit].snap;
                while (mq.size() > hit) mq.delete(mq.size() - 1);
                if (cm && hit > 0) mq.delete(0);
                m_busy = 2;
                m_rreq = 1'b1;
            end else begin
                if (mp && m_busy == 0) m_miss = 1'b1;
                can_alloc = al && (mq.size() < CKPT) && (m_busy == 0);
                if (cm && mq.size() > 0) mq.delete(0);
                if (can_alloc) mq.push_back('{tag: at, snap: sn & ~mask});
                if (m_busy > 0) m_busy--;
            end
        end
        e.status = m_status;
        e.rreq   = m_rreq;
        e.stall  = (mq.size() == CKPT) || (m_busy != 0);
        e.count  = 3'(mq.size());
        e.miss   = m_miss;
        exq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exq.size() > 0) begin
                e = exq.pop_front();
                cmp("ckptCount",     32'(bus.ckptCount),  32'(e.count));
                cmp("stall",         32'(bus.stall),      32'(e.stall));
                cmp("restoreReq",    32'(bus.restoreReq), 32'(e.rreq));
                cmp("missErr",       32'(bus.missErr),    32'(e.miss));
                cmp("statusRestore", bus.statusRestore,   e.status);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.branchAlloc = 1'b0; bus.branchROB = 3'd0; bus.regStatusSnap = 32'd0;
        bus.freeValid = 1'b0; bus.freeReg = 5'd0; bus.branchCommit = 1'b0;
        bus.mispredict = 1'b0; bus.mispredictROB = 3'd0;

        cyc(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        after_edge();
        cmp("reset_count", 32'(bus.ckptCount), 32'd0);
        cmp("reset_status", bus.statusRestore, 32'd0);

        // Fill all four slots, then a fifth allocation must be ignored.
        cyc(1'b0, 1'b1, 3'd1, 32'h10, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd2, 32'h20, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd3, 32'h40, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd4, 32'h80, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd5, 32'hFF, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        after_edge();
        cmp("full_count", 32'(bus.ckptCount), 32'd4);
        cmp("full_stall", 32'(bus.stall), 32'd1);

        cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 3'd2);
        after_edge();
        cmp("mp2_rreq", 32'(bus.restoreReq), 32'd1);
        cmp("mp2_status", bus.statusRestore, 32'h20);
        cmp("mp2_count", 32'(bus.ckptCount), 32'd1);
        idle(1);
        after_edge();
        cmp("recover_stall", 32'(bus.stall), 32'd1);
        idle(1);
        after_edge();
        cmp("idle_stall", 32'(bus.stall), 32'd0);

        // Free applied to a stored snapshot before it is restored.
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd3, 32'h6, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 5'd1, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 3'd3);
        after_edge();
        cmp("free_status", bus.statusRestore, 32'h4);
        idle(2);

        // Pointer wrap-around.
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 1'b1, 3'(i), $urandom, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
            cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 3'd0);
        end
        cyc(1'b0, 1'b1, 3'd7, 32'h1, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 3'd7);
        after_edge();
        cmp("wrap_status", bus.statusRestore, 32'h1);
        cmp("wrap_rreq", 32'(bus.restoreReq), 32'd1);
        idle(2);

        // Unmatched tag sets the sticky error only.
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 3'd6);
        after_edge();
        cmp("miss_err", 32'(bus.missErr), 32'd1);
        cmp("miss_rreq", 32'(bus.restoreReq), 32'd0);
        idle(1);

        // Commit + alloc + mispredict in one cycle.
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd1, 32'h3, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd2, 32'h5, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 3'd3, 32'h9, 1'b0, 5'd0, 1'b1, 1'b1, 3'd2);
        after_edge();
        cmp("combo_count", 32'(bus.ckptCount), 32'd0);
        cmp("combo_rreq", 32'(bus.restoreReq), 32'd1);

        // Reset during recovery aborts it.
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        idle(1);
        cyc(1'b0, 1'b1, 3'd4, 32'hA, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 3'd4);
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 1) != 0,
                3'($urandom_range(0, 7)),
                $urandom,
                $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 31)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0,
                3'($urandom_range(0, 7)));
        end
        idle(2);
        after_edge();
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_checkpoint_ctrl.md
BRANCH_CHECKPOINT_CTRL -- requirements
Module: branch_checkpoint_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- REG, 4, register index MSB (32 architectural registers).
- WIDTH, 31, busy-vector MSB.
- ROB, 2, ROB tag MSB.
- CKPT, 4, checkpoint slot count (power of two).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- branchAlloc, in, 1, rename-stage branch requests a checkpoint.
- branchROB, in, ROB+1, ROB tag of the allocating branch.
- regStatusSnap, in, WIDTH+1, busy vector to be saved.
- freeValid, in, 1, committing instruction frees a register.
- freeReg, in, REG+1, register freed.
- branchCommit, in, 1, oldest branch commits and releases its checkpoint.
- mispredict, in, 1, branch misprediction resolved.
- mispredictROB, in, ROB+1, ROB tag of the mispredicted branch.
- statusRestore, out, WIDTH+1, busy vector sent to the register status reset path.
- restoreReq, out, 1, one-cycle restore strobe (ORed into register status reset).
- stall, out, 1, rename must not allocate.
- ckptCount, out, clog2(CKPT)+1, occupied slots.
- missErr, out, 1, sticky flag: mispredict tag had no matching checkpoint.

Function
REQ-003 Slots SHALL form a circular FIFO in program order, with head/tail pointers wrapping modulo CKPT; each slot holds {valid, tag, snapshot}.
REQ-004 Allocate SHALL occur when branchAlloc & !stall: write {1, branchROB, regStatusSnap} at tail, tail+1, count+1.
REQ-005 branchAlloc while stall SHALL be ignored, with no state change.
REQ-006 branchCommit with count>0 SHALL invalidate head, head+1, count-1; branchCommit with count==0 SHALL be ignored.
REQ-007 freeValid SHALL clear bit freeReg in every valid stored snapshot in the same cycle.
REQ-008 freeValid with freeReg==0 SHALL be ignored.
REQ-009 When allocate and freeValid coincide, the slot being written SHALL also have bit freeReg cleared.
REQ-010 The FSM SHALL have three states: IDLE, RESTORE and RECOVER.
REQ-011 IDLE SHALL go to RESTORE on a mispredict whose tag matches a valid slot.
REQ-012 RESTORE SHALL go to RECOVER unconditionally.
REQ-013 RECOVER SHALL go to IDLE unconditionally.
REQ-014 Mispredict in cycle N with matching slot i SHALL:
- register statusRestore = slot i snapshot with the cycle-N freeValid clear applied;
- set tail=i;
- invalidate slot i and all younger slots;
- set count = distance head to i.
REQ-015 In cycle N+1 (RESTORE), restoreReq SHALL be 1; it SHALL be 0 in every other cycle.
REQ-016 Mispredict SHALL have priority over a same-cycle branchAlloc; that allocation SHALL be dropped.
REQ-017 A same-cycle branchCommit SHALL still release head when head != i.
REQ-018 Mispredict with no tag match SHALL cause no state change and SHALL set missErr, which holds until reset.
REQ-019 Mispredict while the FSM is in RESTORE or RECOVER SHALL be ignored.
REQ-020 stall SHALL equal (count==CKPT) | (state!=IDLE), combinationally.
REQ-021 statusRestore SHALL hold its last restored value outside RESTORE.
REQ-022 Tag match SHALL compare only valid slots; if several valid slots match, the oldest SHALL be selected.

Reset
REQ-023 reset SHALL set head=tail=0, count=0, all slots invalid, state=IDLE, restoreReq=0, statusRestore=0, missErr=0.
REQ-024 reset SHALL take priority over all other inputs.
REQ-025 reset asserted in RESTORE or RECOVER SHALL abort the recovery with no further restoreReq.

Verification
REQ-026 Allocate tags 1,2,3,4 with snapshots 0x10,0x20,0x40,0x80 -> ckptCount=4, stall=1; a fifth branchAlloc with tag 5 is ignored and count stays 4.
REQ-027 From the REQ-026 state, mispredict tag 2 -> next cycle restoreReq=1 and statusRestore=0x20; ckptCount=1; stall=1 for 2 cycles, then 0.
REQ-028 Snapshot 0x0000_0006 stored, then freeValid with freeReg=1, then mispredict on that tag -> statusRestore=0x0000_0004.
REQ-029 With CKPT=4, allocate and commit 6 branches alternately, then allocate tag 7 (snapshot 0x1) and mispredict tag 7 -> correct wrap-around and statusRestore=0x1.
REQ-030 Mispredict tag 6 with no such slot -> missErr=1, restoreReq stays 0, count unchanged.
REQ-031 Same cycle: branchCommit (head tag 1), branchAlloc tag 3, mispredict tag 2 -> head released, tag 3 dropped, count=0, restoreReq next cycle.
